// File: rtl/fpu_pkg.sv
// Shared definitions for the FP issue sequencer: op encodings, FSM states, op classifiers.
package fpu_pkg;

    localparam logic [3:0] OP_S_ADD = 4'b0000;
    localparam logic [3:0] OP_S_EQ  = 4'b0001;
    localparam logic [3:0] OP_S_LT  = 4'b0010;
    localparam logic [3:0] OP_S_LE  = 4'b0011;
    localparam logic [3:0] OP_D_ADD = 4'b0100;
    localparam logic [3:0] OP_D_EQ  = 4'b0101;
    localparam logic [3:0] OP_D_LT  = 4'b0111;
    localparam logic [3:0] OP_D_LE  = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_WB_LO = 3'd2,
        ST_WB_HI = 3'd3,
        ST_FCC   = 3'd4,
        ST_ERR   = 3'd5
    } fpu_state_t;

    function automatic logic is_double(input logic [3:0] op);
        return (op == OP_D_ADD) || (op == OP_D_EQ) || (op == OP_D_LT) || (op == OP_D_LE);
    endfunction

    function automatic logic is_add(input logic [3:0] op);
        return (op == OP_S_ADD) || (op == OP_D_ADD);
    endfunction

    function automatic logic is_cmp(input logic [3:0] op);
        return (op == OP_S_EQ) || (op == OP_S_LT) || (op == OP_S_LE) ||
               (op == OP_D_EQ) || (op == OP_D_LT) || (op == OP_D_LE);
    endfunction

    // A double add needs an even base so the pair is {fd, fd|1}.
    function automatic logic is_legal(input logic [3:0] op, input logic [4:0] fd);
        logic ok;
        case (op)
            OP_S_ADD, OP_S_EQ, OP_S_LT, OP_S_LE,
            OP_D_EQ, OP_D_LT, OP_D_LE: ok = 1'b1;
            OP_D_ADD:                  ok = ~fd[0];
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// Loadable down-counter timing the ALU execute phase; o_zero marks the result-capture cycle.
module fpu_lat_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Sequences one FP op at a time through the shared ALU and performs register/FCC writeback.
// Optional macro FPU_HAZARD_EN enables the pending-write hazard probe on chk_reg.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int ADD_LAT = 3,
    parameter int CMP_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [4:0]  req_fd,
    output logic [3:0]  alu_ctrl,
    output logic [63:0] alu_in1,
    output logic [63:0] alu_in2,
    input  logic [63:0] alu_out,
    input  logic        alu_con,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        fcc_we,
    output logic        fcc_val,
    output logic        done,
    output logic        err,
    input  logic [4:0]  chk_reg,
    output logic        hazard
);

    localparam int MAX_LAT = (ADD_LAT > CMP_LAT) ? ADD_LAT : CMP_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    fpu_state_t  r_state;
    logic [3:0]  r_op;
    logic [4:0]  r_fd;
    logic [31:0] r_res_hi;
    logic        r_req_ready;
    logic [3:0]  r_alu_ctrl;
    logic [63:0] r_alu_in1;
    logic [63:0] r_alu_in2;
    logic        r_wb_en;
    logic [4:0]  r_wb_addr;
    logic [31:0] r_wb_data;
    logic        r_fcc_we;
    logic        r_fcc_val;
    logic        r_done;
    logic        r_err;

    logic             w_accept;
    logic             w_legal;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_load_val;

    assign w_accept   = (r_state == ST_IDLE) && req_valid && r_req_ready;
    assign w_legal    = is_legal(req_op, req_fd);
    assign w_load_val = is_add(req_op) ? CNT_W'(ADD_LAT - 1) : CNT_W'(CMP_LAT - 1);

    fpu_lat_counter #(
        .WIDTH(CNT_W)
    ) u_lat_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_accept && w_legal),
        .i_load_val(w_load_val),
        .i_dec     (r_state == ST_EXEC),
        .o_zero    (w_cnt_zero)
    );

    // Every strobe is computed one cycle ahead so the outputs come straight from flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_fd        <= '0;
            r_res_hi    <= '0;
            r_req_ready <= 1'b1;
            r_alu_ctrl  <= '0;
            r_alu_in1   <= '0;
            r_alu_in2   <= '0;
            r_wb_en     <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_fcc_we    <= 1'b0;
            r_fcc_val   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_fcc_we  <= 1'b0;
            r_fcc_val <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op        <= req_op;
                        r_fd        <= req_fd;
                        r_req_ready <= 1'b0;
                        if (w_legal) begin
                            r_state    <= ST_EXEC;
                            r_alu_ctrl <= req_op;
                            r_alu_in1  <= req_a;
                            r_alu_in2  <= req_b;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end

                ST_EXEC: begin
                    if (w_cnt_zero) begin
                        r_alu_ctrl <= '0;
                        r_alu_in1  <= '0;
                        r_alu_in2  <= '0;
                        r_res_hi   <= alu_out[63:32];
                        if (is_cmp(r_op)) begin
                            r_state   <= ST_FCC;
                            r_fcc_we  <= 1'b1;
                            r_fcc_val <= alu_con;
                            r_done    <= 1'b1;
                        end else begin
                            // Double writes the low word first, single writes its only word.
                            r_state   <= ST_WB_LO;
                            r_wb_en   <= 1'b1;
                            r_wb_addr <= r_fd;
                            r_wb_data <= is_double(r_op) ? alu_out[31:0] : alu_out[63:32];
                            r_done    <= ~is_double(r_op);
                        end
                    end
                end

                ST_WB_LO: begin
                    if (is_double(r_op)) begin
                        r_state   <= ST_WB_HI;
                        r_wb_en   <= 1'b1;
                        r_wb_addr <= r_fd | 5'd1;
                        r_wb_data <= r_res_hi;
                        r_done    <= 1'b1;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b1;
                    end
                end

                ST_WB_HI, ST_FCC, ST_ERR: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign alu_ctrl  = r_alu_ctrl;
    assign alu_in1   = r_alu_in1;
    assign alu_in2   = r_alu_in2;
    assign wb_en     = r_wb_en;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;
    assign fcc_we    = r_fcc_we;
    assign fcc_val   = r_fcc_val;
    assign done      = r_done;
    assign err       = r_err;

`ifdef FPU_HAZARD_EN
    logic w_add_busy;

    // Pending until the final writeback state has been left.
    assign w_add_busy = (r_state != ST_IDLE) && (r_state != ST_ERR) && is_add(r_op);
    assign hazard     = w_add_busy &&
                        ((chk_reg == r_fd) || (is_double(r_op) && (chk_reg == (r_fd | 5'd1))));
`else
    logic w_unused_chk;

    assign w_unused_chk = ^chk_reg;
    assign hazard       = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed scenarios plus randomized ops against a trace model.
module tb_fpu_issue_ctrl;

    localparam int ADD_LAT = 3;
    localparam int CMP_LAT = 1;
    localparam int NREC    = ((ADD_LAT > CMP_LAT) ? ADD_LAT : CMP_LAT) + 4;
`ifdef FPU_HAZARD_EN
    localparam bit HZ_EN = 1'b1;
`else
    localparam bit HZ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [4:0]  req_fd;
    logic [3:0]  alu_ctrl;
    logic [63:0] alu_in1;
    logic [63:0] alu_in2;
    logic [63:0] alu_out;
    logic        alu_con;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        fcc_we;
    logic        fcc_val;
    logic        done;
    logic        err;
    logic [4:0]  chk_reg;
    logic        hazard;

    int tests_run    = 0;
    int tests_failed = 0;

    // Observed trace (index = cycles after the accept edge) and model trace.
    logic [3:0]  t_ctrl [32];
    logic [63:0] t_in1 [32];
    logic [63:0] t_in2 [32];
    logic        t_wb_en [32];
    logic [4:0]  t_wb_addr [32];
    logic [31:0] t_wb_data [32];
    logic        t_fcc_we [32];
    logic        t_fcc_val [32];
    logic        t_done [32];
    logic        t_err [32];
    logic        t_ready [32];
    logic        t_hz [32];

    logic [3:0]  e_ctrl [32];
    logic [63:0] e_in1 [32];
    logic [63:0] e_in2 [32];
    logic        e_wb_en [32];
    logic [4:0]  e_wb_addr [32];
    logic [31:0] e_wb_data [32];
    logic        e_fcc_we [32];
    logic        e_fcc_val [32];
    logic        e_done [32];
    logic        e_err [32];
    logic        e_ready [32];
    logic        e_hz [32];

    fpu_issue_ctrl #(
        .ADD_LAT(ADD_LAT),
        .CMP_LAT(CMP_LAT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_fd   (req_fd),
        .alu_ctrl (alu_ctrl),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .alu_out  (alu_out),
        .alu_con  (alu_con),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .fcc_we   (fcc_we),
        .fcc_val  (fcc_val),
        .done     (done),
        .err      (err),
        .chk_reg  (chk_reg),
        .hazard   (hazard)
    );

    always #5 clk = ~clk;

    function automatic bit m_legal(input logic [3:0] op, input logic [4:0] fd);
        if (op > 4'd8 || op == 4'd6) return 1'b0;
        if (op == 4'd4 && fd[0]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_add(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd4);
    endfunction

    // Cycle (after accept) carrying done or err.
    function automatic int m_last(input logic [3:0] op, input logic [4:0] fd);
        if (!m_legal(op, fd)) return 1;
        if (op == 4'd4) return ADD_LAT + 2;
        if (op == 4'd0) return ADD_LAT + 1;
        return CMP_LAT + 1;
    endfunction

    task automatic model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] fd, input logic [63:0] res, input logic con,
                         input logic [4:0] chk);
        bit lg, ad, dbl;
        int lat, last;
        lg   = m_legal(op, fd);
        ad   = m_add(op);
        dbl  = (op == 4'd4);
        lat  = ad ? ADD_LAT : CMP_LAT;
        last = m_last(op, fd);
        for (int k = 1; k <= NREC; k++) begin
            e_ctrl[k]    = (lg && k <= lat) ? op : 4'd0;
            e_in1[k]     = (lg && k <= lat) ? a : 64'd0;
            e_in2[k]     = (lg && k <= lat) ? b : 64'd0;
            e_wb_en[k]   = 1'b0;
            e_wb_addr[k] = 5'd0;
            e_wb_data[k] = 32'd0;
            e_fcc_we[k]  = 1'b0;
            e_fcc_val[k] = 1'b0;
            e_done[k]    = lg && (k == last);
            e_err[k]     = !lg && (k == 1);
            e_ready[k]   = (k > last);
            e_hz[k]      = HZ_EN && lg && ad && (k <= last) &&
                           ((chk == fd) || (dbl && chk == 5'(fd + 1)));
            if (lg && ad && k == lat + 1) begin
                e_wb_en[k]   = 1'b1;
                e_wb_addr[k] = fd;
                e_wb_data[k] = dbl ? res[31:0] : res[63:32];
            end
            if (lg && dbl && k == lat + 2) begin
                e_wb_en[k]   = 1'b1;
                e_wb_addr[k] = 5'(fd + 1);
                e_wb_data[k] = res[63:32];
            end
            if (lg && !ad && k == lat + 1) begin
                e_fcc_we[k]  = 1'b1;
                e_fcc_val[k] = con;
            end
        end
    endtask

    // Issues one op and records NREC cycles of outputs; the ALU presents res only on its final cycle.
    task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] fd, input logic [63:0] res, input logic con,
                         input logic [4:0] chk, input bit noise);
        int lat, last, w;
        lat  = m_add(op) ? ADD_LAT : CMP_LAT;
        last = m_last(op, fd);
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_wait got %0b exp 1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_fd    = fd;
        alu_out   = {$urandom, $urandom};
        alu_con   = 1'($urandom);
        chk_reg   = chk;
        @(posedge clk);
        for (int k = 1; k <= NREC; k++) begin
            @(negedge clk);
            req_valid = noise && (k <= last);
            req_op    = 4'($urandom);
            req_a     = {$urandom, $urandom};
            req_b     = {$urandom, $urandom};
            req_fd    = 5'($urandom);
            alu_out   = (k == lat) ? res : {$urandom, $urandom};
            alu_con   = (k == lat) ? con : 1'($urandom);
            chk_reg   = chk;
            #1;
            t_ctrl[k]    = alu_ctrl;
            t_in1[k]     = alu_in1;
            t_in2[k]     = alu_in2;
            t_wb_en[k]   = wb_en;
            t_wb_addr[k] = wb_addr;
            t_wb_data[k] = wb_data;
            t_fcc_we[k]  = fcc_we;
            t_fcc_val[k] = fcc_val;
            t_done[k]    = done;
            t_err[k]     = err;
            t_ready[k]   = req_ready;
            t_hz[k]      = hazard;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_a     = 64'd0;
        req_b     = 64'd0;
        req_fd    = 5'd0;
        alu_out   = 64'd0;
        alu_con   = 1'b0;
        chk_reg   = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %0b exp 1", req_ready); end
        tests_run++;
        if ({wb_en, fcc_we, fcc_val, done, err, hazard} !== 6'd0) begin
            tests_failed++; $display("FAIL reset_strobes got %06b exp 000000", {wb_en, fcc_we, fcc_val, done, err, hazard});
        end
        tests_run++;
        if ({alu_ctrl, alu_in1, alu_in2, wb_addr, wb_data} !== '0) begin
            tests_failed++; $display("FAIL reset_buses got ctrl=%0h in1=%0h wb_data=%0h exp 0", alu_ctrl, alu_in1, wb_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_ready got %0b exp 1", req_ready); end
    endtask

    task automatic test_single_add;
        do_op(4'd0, 64'h3F800000_00000000, 64'h40000000_00000000, 5'd4, 64'h40400000_DEADBEEF, 1'b0, 5'd0, 1'b0);
        for (int k = 1; k <= ADD_LAT + 1; k++) begin
            tests_run++;
            if (t_in1[k] !== ((k <= 3) ? 64'h3F800000_00000000 : 64'd0) || t_ctrl[k] !== 4'd0) begin
                tests_failed++; $display("FAIL sadd_drive k=%0d got in1=%0h exp drive for 3 cycles", k, t_in1[k]);
            end
        end
        tests_run++;
        if ({t_wb_en[4], t_wb_addr[4], t_wb_data[4], t_done[4]} !== {1'b1, 5'd4, 32'h40400000, 1'b1}) begin
            tests_failed++; $display("FAIL sadd_wb got en=%0b addr=%0d data=%0h done=%0b exp 1 4 40400000 1", t_wb_en[4], t_wb_addr[4], t_wb_data[4], t_done[4]);
        end
        tests_run++;
        if (t_ready[5] !== 1'b1 || t_ready[4] !== 1'b0 || t_wb_en[5] !== 1'b0) begin
            tests_failed++; $display("FAIL sadd_ready got r4=%0b r5=%0b exp 0 1", t_ready[4], t_ready[5]);
        end
    endtask

    task automatic test_double_add;
        do_op(4'd4, 64'h3FF00000_00000000, 64'h40000000_00000000, 5'd6, 64'h40080000_00000000, 1'b0, 5'd0, 1'b0);
        tests_run++;
        if ({t_wb_en[4], t_wb_addr[4], t_wb_data[4], t_done[4]} !== {1'b1, 5'd6, 32'h00000000, 1'b0}) begin
            tests_failed++; $display("FAIL dadd_lo got en=%0b addr=%0d data=%0h done=%0b exp 1 6 0 0", t_wb_en[4], t_wb_addr[4], t_wb_data[4], t_done[4]);
        end
        tests_run++;
        if ({t_wb_en[5], t_wb_addr[5], t_wb_data[5], t_done[5]} !== {1'b1, 5'd7, 32'h40080000, 1'b1}) begin
            tests_failed++; $display("FAIL dadd_hi got en=%0b addr=%0d data=%0h done=%0b exp 1 7 40080000 1", t_wb_en[5], t_wb_addr[5], t_wb_data[5], t_done[5]);
        end
        tests_run++;
        if (t_ready[6] !== 1'b1 || t_wb_en[6] !== 1'b0) begin
            tests_failed++; $display("FAIL dadd_end got ready=%0b wb_en=%0b exp 1 0", t_ready[6], t_wb_en[6]);
        end
    endtask

    task automatic test_compare;
        do_op(4'd7, 64'h3FF00000_00000000, 64'h40000000_00000000, 5'd3, 64'd0, 1'b1, 5'd3, 1'b0);
        tests_run++;
        if (t_ctrl[1] !== 4'd7 || t_ctrl[2] !== 4'd0) begin
            tests_failed++; $display("FAIL cmp_ctrl got %0h,%0h exp 7,0", t_ctrl[1], t_ctrl[2]);
        end
        tests_run++;
        if ({t_fcc_we[2], t_fcc_val[2], t_done[2]} !== 3'b111) begin
            tests_failed++; $display("FAIL cmp_fcc got %03b exp 111", {t_fcc_we[2], t_fcc_val[2], t_done[2]});
        end
        for (int k = 1; k <= NREC; k++) begin
            tests_run++;
            if (t_wb_en[k] !== 1'b0 || t_hz[k] !== 1'b0) begin
                tests_failed++; $display("FAIL cmp_nowb k=%0d got wb_en=%0b hz=%0b exp 0 0", k, t_wb_en[k], t_hz[k]);
            end
        end
        tests_run++;
        if (t_ready[3] !== 1'b1 || t_ready[2] !== 1'b0) begin
            tests_failed++; $display("FAIL cmp_ready got r2=%0b r3=%0b exp 0 1", t_ready[2], t_ready[3]);
        end
    endtask

    task automatic test_illegal;
        logic [3:0] ops [2];
        logic [4:0] fds [2];
        ops[0] = 4'd6; fds[0] = 5'd2;
        ops[1] = 4'd4; fds[1] = 5'd5;
        for (int i = 0; i < 2; i++) begin
            do_op(ops[i], 64'h1111, 64'h2222, fds[i], 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, fds[i], 1'b0);
            tests_run++;
            if (t_err[1] !== 1'b1 || t_err[2] !== 1'b0 || t_ready[2] !== 1'b1) begin
                tests_failed++; $display("FAIL illegal%0d got err1=%0b err2=%0b ready2=%0b exp 1 0 1", i, t_err[1], t_err[2], t_ready[2]);
            end
            for (int k = 1; k <= NREC; k++) begin
                tests_run++;
                if ({t_ctrl[k], t_in1[k], t_wb_en[k], t_fcc_we[k], t_done[k], t_hz[k]} !== '0) begin
                    tests_failed++; $display("FAIL illegal%0d_quiet k=%0d got ctrl=%0h in1=%0h wb=%0b fcc=%0b done=%0b", i, k, t_ctrl[k], t_in1[k], t_wb_en[k], t_fcc_we[k], t_done[k]);
                end
            end
        end
    endtask

    task automatic test_hazard;
        logic [4:0] probes [2];
        probes[0] = 5'd7;
        probes[1] = 5'd8;
        for (int i = 0; i < 2; i++) begin
            do_op(4'd4, 64'h5, 64'h6, 5'd6, 64'h1234_5678_9ABC_DEF0, 1'b0, probes[i], 1'b0);
            for (int k = 1; k <= ADD_LAT + 3; k++) begin
                tests_run++;
                if (t_hz[k] !== (HZ_EN && i == 0 && k <= ADD_LAT + 2)) begin
                    tests_failed++; $display("FAIL hazard chk=%0d k=%0d got %0b exp %0b", probes[i], k, t_hz[k], HZ_EN && i == 0 && k <= ADD_LAT + 2);
                end
            end
        end
    endtask

    task automatic test_reset_mid_op;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'd4;
        req_a     = 64'hAAAA;
        req_b     = 64'hBBBB;
        req_fd    = 5'd6;
        chk_reg   = 5'd6;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        alu_out = 64'h40080000_00000000;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || {alu_ctrl, alu_in1, alu_in2, wb_en, wb_addr, wb_data, fcc_we, fcc_val, done, err, hazard} !== '0) begin
            tests_failed++; $display("FAIL midreset got ready=%0b in1=%0h hz=%0b exp ready=1 rest 0", req_ready, alu_in1, hazard);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            alu_out = {$urandom, $urandom};
            tests_run++;
            if (wb_en !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
                tests_failed++; $display("FAIL midreset_after k=%0d got wb_en=%0b done=%0b ready=%0b exp 0 0 1", k, wb_en, done, req_ready);
            end
        end
    endtask

    task automatic test_random;
        logic [3:0]  legal_ops [8];
        logic [3:0]  op;
        logic [4:0]  fd, chk;
        logic [63:0] a, b, res;
        logic        con;
        legal_ops[0] = 4'd0; legal_ops[1] = 4'd1; legal_ops[2] = 4'd2; legal_ops[3] = 4'd3;
        legal_ops[4] = 4'd4; legal_ops[5] = 4'd5; legal_ops[6] = 4'd7; legal_ops[7] = 4'd8;
        for (int n = 0; n < 60; n++) begin
            op  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 7)];
            fd  = 5'($urandom);
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            res = {$urandom, $urandom};
            con = 1'($urandom);
            case ($urandom_range(0, 2))
                0:       chk = fd;
                1:       chk = 5'(fd + 1);
                default: chk = 5'($urandom);
            endcase
            model(op, a, b, fd, res, con, chk);
            do_op(op, a, b, fd, res, con, chk, n[0]);
            for (int k = 1; k <= NREC; k++) begin
                tests_run++;
                if (t_ctrl[k] !== e_ctrl[k] || t_in1[k] !== e_in1[k] || t_in2[k] !== e_in2[k]) begin
                    tests_failed++; $display("FAIL rand_alu n=%0d op=%0h k=%0d got ctrl=%0h in1=%0h exp ctrl=%0h in1=%0h", n, op, k, t_ctrl[k], t_in1[k], e_ctrl[k], e_in1[k]);
                end
                tests_run++;
                if (t_wb_en[k] !== e_wb_en[k] || t_wb_addr[k] !== e_wb_addr[k] || t_wb_data[k] !== e_wb_data[k]) begin
                    tests_failed++; $display("FAIL rand_wb n=%0d op=%0h fd=%0d k=%0d got %0b/%0d/%0h exp %0b/%0d/%0h", n, op, fd, k, t_wb_en[k], t_wb_addr[k], t_wb_data[k], e_wb_en[k], e_wb_addr[k], e_wb_data[k]);
                end
                tests_run++;
                if (t_fcc_we[k] !== e_fcc_we[k] || t_fcc_val[k] !== e_fcc_val[k]) begin
                    tests_failed++; $display("FAIL rand_fcc n=%0d op=%0h k=%0d got %0b/%0b exp %0b/%0b", n, op, k, t_fcc_we[k], t_fcc_val[k], e_fcc_we[k], e_fcc_val[k]);
                end
                tests_run++;
                if (t_done[k] !== e_done[k] || t_err[k] !== e_err[k] || t_ready[k] !== e_ready[k]) begin
                    tests_failed++; $display("FAIL rand_ctl n=%0d op=%0h fd=%0d k=%0d got done=%0b err=%0b rdy=%0b exp %0b %0b %0b", n, op, fd, k, t_done[k], t_err[k], t_ready[k], e_done[k], e_err[k], e_ready[k]);
                end
                tests_run++;
                if (t_hz[k] !== e_hz[k]) begin
                    tests_failed++; $display("FAIL rand_hz n=%0d op=%0h fd=%0d chk=%0d k=%0d got %0b exp %0b", n, op, fd, chk, k, t_hz[k], e_hz[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_add;
        test_double_add;
        test_compare;
        test_illegal;
        test_hazard;
        test_reset_mid_op;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Sequencer between FP decode and the shared 64-bit FP ALU.
- Accepts one FP operation at a time over a valid/ready handshake, drives ALU control and operands for a fixed per-class latency, and captures result and condition bit.
- Single add writes one 32-bit FP register; double add writes an even/odd register pair over two cycles; compares update the FP condition flag (FCC).

Parameters:
ADD_LAT, 3, ALU cycles for single/double add (>=1)
CMP_LAT, 1, ALU cycles for compares (>=1)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  operation offered
req_ready  out  1  high only in IDLE
req_op  in  4  0000 s.add, 0001 s.eq, 0010 s.lt, 0011 s.le, 0100 d.add, 0101 d.eq, 0111 d.lt, 1000 d.le
req_a  in  64  operand 1 (single in [63:32])
req_b  in  64  operand 2 (single in [63:32])
req_fd  in  5  destination register (even for double add)
alu_ctrl  out  4  to ALU control
alu_in1  out  64  to ALU in1
alu_in2  out  64  to ALU in2
alu_out  in  64  ALU result
alu_con  in  1  ALU condition result
wb_en  out  1  FP register write strobe
wb_addr  out  5  FP register index
wb_data  out  32  FP register write data
fcc_we  out  1  FCC write strobe
fcc_val  out  1  FCC value
done  out  1  one-cycle pulse on final cycle of a legal op
err  out  1  one-cycle pulse for an illegal op
chk_reg  in  5  register index probed by decode
hazard  out  1  chk_reg is a pending write target

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0 except req_ready=1. Any in-flight op is dropped with no write.
- Handshake: accept when req_valid && req_ready. Latch op, a, b and fd. req_ready=0 from the next cycle until return to IDLE. No overlap: minimum spacing between accepts is latency plus writeback plus one IDLE cycle.
- States: IDLE, EXEC, WB_LO, WB_HI, FCC, ERR.
- IDLE to EXEC on a legal accept. Counter loads LAT-1, where LAT is ADD_LAT for add and CMP_LAT for compare.
- EXEC: alu_ctrl, alu_in1 and alu_in2 hold the latched values, stable every EXEC cycle. Counter decrements each cycle. On the counter==0 cycle, capture alu_out/alu_con into the result registers.
  - Add goes to WB_LO.
  - Compare goes to FCC.
- Outside EXEC, alu_ctrl, alu_in1 and alu_in2 are 0.
- WB_LO:
  - wb_en=1, wb_addr=fd.
  - Single add: wb_data=res[63:32]; done=1; next state IDLE.
  - Double add: wb_data=res[31:0]; next state WB_HI.
- WB_HI: wb_en=1, wb_addr=fd|1, wb_data=res[63:32], done=1; next state IDLE.
- FCC: fcc_we=1, fcc_val=captured con, done=1; next state IDLE.
- Illegal op: req_op 0110 or >=1001, or d.add with odd fd.
  - The op is still accepted (handshake completes).
  - Goes to ERR for one cycle: err=1, no ALU drive, no writes. Next state IDLE.
- Latency from accept edge to done:
  - Single add: ADD_LAT+1 cycles.
  - Double add: ADD_LAT+2 cycles.
  - Compare: CMP_LAT+1 cycles.
- wb_*, fcc_* and done are registered state decodes and glitch-free. wb_data is 0 when wb_en=0.
- req_* is ignored while not ready.
- Without FPU_HAZARD_EN: hazard=0 constantly.

Optional Feature:
- Macro FPU_HAZARD_EN.
- Defined: hazard=1 combinationally when state is not IDLE or ERR, op is an add, and either chk_reg==fd, or the op is double and chk_reg==(fd|1).
  - hazard deasserts in the cycle after the final writeback.
  - Compares never raise hazard.
- Undefined: hazard tied 0; chk_reg unused.

Decomposition:
- Package fpu_pkg holds:
  - localparams for the eight op encodings;
  - the state encoding (3-bit);
  - functions is_double(op), is_cmp(op), is_legal(op, fd).
- One natural sub-module, fpu_lat_counter: loadable down-counter with a zero flag, width $clog2(max(ADD_LAT,CMP_LAT))+1.
- Writeback muxing stays in the top module.

Test Plan:
- Reset mid-op: reset_n=0 during EXEC of a d.add.
  - Required: immediately all outputs 0 and req_ready=1.
  - After release: no wb_en ever.
- Single add: ADD_LAT=3, op 0000, a=0x3F800000_00000000, b=0x40000000_00000000, fd=4, ALU model returns 0x40400000_xxxxxxxx.
  - Required: alu_ctrl=0000 for exactly 3 cycles.
  - Then wb_en=1, wb_addr=4, wb_data=0x40400000, done=1 at accept+4.
- Double add: op 0100, fd=6, ALU returns 0x40080000_00000000.
  - Cycle accept+4: wb to reg 6, data 0x00000000.
  - Cycle accept+5: wb to reg 7, data 0x40080000, with done.
- Compare: CMP_LAT=1, op 0111, ALU con=1.
  - Required: at accept+2, fcc_we=1, fcc_val=1, done=1.
  - No wb_en; req_ready=1 at accept+3.
- Illegal ops: op 0110; then op 0100 with fd=5.
  - Each: err pulse at accept+1, no ALU drive, no writes, ready next cycle.
- FPU_HAZARD_EN: d.add with fd=6 in flight; probe chk_reg=7, then 8.
  - Required: hazard=1 for 7 and hazard=0 for 8.
  - hazard drops the cycle after WB_HI.
